// File: rtl/brownout_ctrl_pkg.sv
// rtl/brownout_ctrl_pkg.sv - shared types and constants for the brownout supervisor
package brownout_ctrl_pkg;

    typedef enum logic [1:0] {
        S_OFF     = 2'd0,
        S_SETTLE  = 2'd1,
        S_ARMED   = 2'd2,
        S_TRIPPED = 2'd3
    } state_t;

    // Consecutive disagreeing samples needed before the debounce filter flips
    localparam int DEBOUNCE_CYCLES = 4;

    // Bit positions inside status / irq_en / clr
    localparam int ST_BROUT  = 0;
    localparam int ST_VUNDER = 1;

endpackage

// File: rtl/brownout_sync_filt.sv
// rtl/brownout_sync_filt.sv - 2-flop synchronizer with optional debounce filter
//
// Optional feature macro: BROWNOUT_CTRL_DEBOUNCE_EN (adds a debounce filter
// after the synchronizer; without it the synchronizer output is used directly).
//
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   din  - asynchronous level from the analog macro
//   dout - synchronized (and optionally debounced) level
module brownout_sync_filt
    import brownout_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic meta;
    logic sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= din;
            sync <= meta;
        end
    end

`ifdef BROWNOUT_CTRL_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] cnt;
    logic          filt;

    // cnt counts consecutive samples that disagree with filt; any agreeing
    // sample restarts the count, so short glitches never reach dout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            filt <= 1'b0;
        end else if (sync == filt) begin
            cnt <= '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            filt <= sync;
            cnt  <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign dout = filt;
`else
    assign dout = sync;
`endif

endmodule

// File: rtl/brownout_ctrl.sv
// rtl/brownout_ctrl.sv - brownout macro supervisor: settle sequencing, status, irq, reset request
//
// Optional feature macro: BROWNOUT_CTRL_DEBOUNCE_EN (debounce on out/vunder).
//
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   cfg_ena, cfg_otrip,
//   cfg_vtrip, cfg_rst_en    - software configuration
//   irq_en[1:0], clr[1:0]    - irq enables and write-1-to-clear, [0] brownout, [1] vunder
//   out, vunder              - asynchronous macro indications
//   ena, otrip, vtrip        - drive to the macro
//   ready                    - detections unmasked
//   status[1:0], irq         - sticky flags and registered interrupt
//   rst_req                  - reset request to SoC reset controller
module brownout_ctrl
    import brownout_ctrl_pkg::*;
#(
    parameter int SETTLE_CYCLES    = 1024,
    parameter int RST_PULSE_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_ena,
    input  logic [2:0] cfg_otrip,
    input  logic [2:0] cfg_vtrip,
    input  logic       cfg_rst_en,
    input  logic [1:0] irq_en,
    input  logic [1:0] clr,
    input  logic       out,
    input  logic       vunder,
    output logic       ena,
    output logic [2:0] otrip,
    output logic [2:0] vtrip,
    output logic       ready,
    output logic [1:0] status,
    output logic       irq,
    output logic       rst_req
);

    localparam int SCW = $clog2(SETTLE_CYCLES + 1);
    localparam int PCW = $clog2(RST_PULSE_CYCLES + 1);

    logic out_f;
    logic vun_f;

    brownout_sync_filt u_out_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (out),
        .dout (out_f)
    );

    brownout_sync_filt u_vun_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (vunder),
        .dout (vun_f)
    );

    state_t         state, state_nxt;
    logic [SCW-1:0] scnt, scnt_nxt;
    logic [PCW-1:0] pcnt, pcnt_nxt;
    logic [2:0]     otrip_nxt, vtrip_nxt;
    logic [1:0]     status_nxt, set;
    logic           ena_nxt, ready_nxt, irq_nxt, rst_req_nxt;
    logic           cfg_diff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_OFF;
            scnt    <= '0;
            pcnt    <= '0;
            ena     <= 1'b0;
            otrip   <= '0;
            vtrip   <= '0;
            ready   <= 1'b0;
            status  <= '0;
            irq     <= 1'b0;
            rst_req <= 1'b0;
        end else begin
            state   <= state_nxt;
            scnt    <= scnt_nxt;
            pcnt    <= pcnt_nxt;
            ena     <= ena_nxt;
            otrip   <= otrip_nxt;
            vtrip   <= vtrip_nxt;
            ready   <= ready_nxt;
            status  <= status_nxt;
            irq     <= irq_nxt;
            rst_req <= rst_req_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        scnt_nxt  = scnt;
        pcnt_nxt  = pcnt;
        otrip_nxt = otrip;
        vtrip_nxt = vtrip;
        set       = '0;
        cfg_diff  = (cfg_otrip != otrip) || (cfg_vtrip != vtrip);

        if (state == S_ARMED || state == S_TRIPPED) begin
            set[ST_BROUT]  = out_f;
            set[ST_VUNDER] = vun_f;
        end
        // Setting wins over a same-cycle clear so no event is lost
        status_nxt = (status & ~clr) | set;

        case (state)
            S_OFF: begin
                otrip_nxt = cfg_otrip;
                vtrip_nxt = cfg_vtrip;
                if (cfg_ena) begin
                    state_nxt = S_SETTLE;
                    scnt_nxt  = SCW'(SETTLE_CYCLES - 1);
                end
            end
            S_SETTLE: begin
                if (scnt == '0) begin
                    state_nxt = S_ARMED;
                end else begin
                    scnt_nxt = scnt - 1'b1;
                end
            end
            S_ARMED: begin
                // A trip takes priority; a pending code change waits for its exit
                if (out_f) begin
                    state_nxt = S_TRIPPED;
                    pcnt_nxt  = PCW'(RST_PULSE_CYCLES - 1);
                end else if (cfg_diff) begin
                    otrip_nxt = cfg_otrip;
                    vtrip_nxt = cfg_vtrip;
                    state_nxt = S_SETTLE;
                    scnt_nxt  = SCW'(SETTLE_CYCLES - 1);
                end
            end
            S_TRIPPED: begin
                if (pcnt != '0) begin
                    pcnt_nxt = pcnt - 1'b1;
                end else if (!out_f) begin
                    if (cfg_diff) begin
                        otrip_nxt = cfg_otrip;
                        vtrip_nxt = cfg_vtrip;
                        state_nxt = S_SETTLE;
                        scnt_nxt  = SCW'(SETTLE_CYCLES - 1);
                    end else begin
                        state_nxt = S_ARMED;
                    end
                end
            end
            default: state_nxt = S_OFF;
        endcase

        if (!cfg_ena) begin
            state_nxt = S_OFF;
        end

        // Outputs are registered copies of what the next state implies
        ena_nxt     = (state_nxt != S_OFF);
        ready_nxt   = (state_nxt == S_ARMED) || (state_nxt == S_TRIPPED);
        rst_req_nxt = (state_nxt == S_TRIPPED) && cfg_rst_en;
        irq_nxt     = |(status & irq_en);
    end

endmodule

// File: tb/tb_brownout_ctrl.sv
// tb/tb_brownout_ctrl.sv - self-checking bench for brownout_ctrl
module tb_brownout_ctrl;

`ifdef BROWNOUT_CTRL_DEBOUNCE_EN
    localparam int DB = 4;
    localparam int PL = 5;
`else
    localparam int DB = 0;
    localparam int PL = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cfg_ena = 1'b0;
    logic [2:0] cfg_otrip = '0;
    logic [2:0] cfg_vtrip = '0;
    logic       cfg_rst_en = 1'b0;
    logic [1:0] irq_en = '0;
    logic [1:0] clr = '0;
    logic       out = 1'b0;
    logic       vunder = 1'b0;
    logic       ena;
    logic [2:0] otrip;
    logic [2:0] vtrip;
    logic       ready;
    logic [1:0] status;
    logic       irq;
    logic       rst_req;

    brownout_ctrl #(
        .SETTLE_CYCLES    (16),
        .RST_PULSE_CYCLES (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_ena    (cfg_ena),
        .cfg_otrip  (cfg_otrip),
        .cfg_vtrip  (cfg_vtrip),
        .cfg_rst_en (cfg_rst_en),
        .irq_en     (irq_en),
        .clr        (clr),
        .out        (out),
        .vunder     (vunder),
        .ena        (ena),
        .otrip      (otrip),
        .vtrip      (vtrip),
        .ready      (ready),
        .status     (status),
        .irq        (irq),
        .rst_req    (rst_req)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       ena_c;
        logic [2:0] ot;
        logic [2:0] vt;
        logic       out_i;
        logic       vun_i;
        int         cyc;
        logic [2:0] e_ot;
        logic [2:0] e_vt;
        logic       e_ena;
        logic       e_ready;
        logic [1:0] e_status;
        logic       e_rst;
    } vec_t;

    vec_t tbl[4];

    initial begin
        int rise;
        int width;
        int irq_at;
        bit seen;

        // OFF-state vectors: codes track cfg, detections never set status
        tbl[0] = '{1'b0, 3'd3, 3'd2, 1'b0, 1'b0, 1, 3'd3, 3'd2, 1'b0, 1'b0, 2'b00, 1'b0};
        tbl[1] = '{1'b0, 3'd7, 3'd0, 1'b0, 1'b0, 1, 3'd7, 3'd0, 1'b0, 1'b0, 2'b00, 1'b0};
        tbl[2] = '{1'b0, 3'd0, 3'd5, 1'b1, 1'b1, 4, 3'd0, 3'd5, 1'b0, 1'b0, 2'b00, 1'b0};
        tbl[3] = '{1'b0, 3'd3, 3'd2, 1'b0, 1'b0, 8, 3'd3, 3'd2, 1'b0, 1'b0, 2'b00, 1'b0};

        #1 rst = 1'b1;
        step(2);
        check("reset_ena", 32'(ena), 0);
        check("reset_otrip", 32'(otrip), 0);
        check("reset_vtrip", 32'(vtrip), 0);
        check("reset_ready", 32'(ready), 0);
        check("reset_status", 32'(status), 0);
        check("reset_irq", 32'(irq), 0);
        check("reset_rst_req", 32'(rst_req), 0);
        rst = 1'b0;
        step(1);

        for (int i = 0; i < 4; i++) begin
            cfg_ena   = tbl[i].ena_c;
            cfg_otrip = tbl[i].ot;
            cfg_vtrip = tbl[i].vt;
            out       = tbl[i].out_i;
            vunder    = tbl[i].vun_i;
            step(tbl[i].cyc);
            check($sformatf("tbl%0d_otrip", i), 32'(otrip), 32'(tbl[i].e_ot));
            check($sformatf("tbl%0d_vtrip", i), 32'(vtrip), 32'(tbl[i].e_vt));
            check($sformatf("tbl%0d_ena", i), 32'(ena), 32'(tbl[i].e_ena));
            check($sformatf("tbl%0d_ready", i), 32'(ready), 32'(tbl[i].e_ready));
            check($sformatf("tbl%0d_status", i), 32'(status), 32'(tbl[i].e_status));
            check($sformatf("tbl%0d_rst_req", i), 32'(rst_req), 32'(tbl[i].e_rst));
        end

        // Enable: ena after 1 edge, ready after 17; out held during settle is ignored
        cfg_ena = 1'b1;
        out = 1'b1;
        step(1);
        check("en_ena_1edge", 32'(ena), 1);
        check("en_ready_1edge", 32'(ready), 0);
        step(9);
        out = 1'b0;
        step(6);
        check("en_ready_16edge", 32'(ready), 0);
        step(1);
        check("en_ready_17edge", 32'(ready), 1);
        check("en_status_masked", 32'(status), 0);

        cfg_rst_en = 1'b1;
        irq_en = 2'b01;

`ifdef BROWNOUT_CTRL_DEBOUNCE_EN
        // A 3-cycle pulse is shorter than the debounce window
        seen = 1'b0;
        out = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            step(1);
            if (k == 3) out = 1'b0;
            if (rst_req) seen = 1'b1;
        end
        check("db_short_no_trip", 32'(seen), 0);
        check("db_short_status", 32'(status), 0);
`endif

        // Short pulse: rst_req rises after 3(+DB) edges and lasts exactly 8 cycles
        rise = -1;
        width = 0;
        irq_at = -1;
        out = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            step(1);
            if (k == PL) out = 1'b0;
            if (rst_req) begin
                width++;
                if (rise < 0) rise = k;
            end
            if (irq && irq_at < 0) irq_at = k;
        end
        check("pulse_rise_edge", rise, 3 + DB);
        check("pulse_width", width, 8);
        check("pulse_irq_edge", irq_at, 4 + DB);
        check("pulse_status", 32'(status), 1);
        check("pulse_ready", 32'(ready), 1);

        clr = 2'b01;
        step(1);
        clr = 2'b00;
        check("clr0_status", 32'(status), 0);
        check("clr0_irq_lag", 32'(irq), 1);
        step(1);
        check("clr0_irq", 32'(irq), 0);

        // Long trip with a code change pending
        out = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            if (k == 5) cfg_otrip = 3'd5;
        end
        check("long_rst_req_held", 32'(rst_req), 1);
        check("long_otrip_held", 32'(otrip), 3);
        out = 1'b0;
        step(2 + DB);
        check("long_rst_req_before_exit", 32'(rst_req), 1);
        step(1);
        check("long_rst_req_fall", 32'(rst_req), 0);
        check("long_otrip_new", 32'(otrip), 5);
        check("long_resettle_ready", 32'(ready), 0);
        check("long_resettle_ena", 32'(ena), 1);
        step(15);
        check("long_resettle_ready15", 32'(ready), 0);
        step(1);
        check("long_resettle_ready16", 32'(ready), 1);

        clr = 2'b01;
        step(1);
        clr = 2'b00;
        step(2);

        // vunder with a same-cycle clear: bit stays set, no reset request
        irq_en = 2'b11;
        vunder = 1'b1;
        for (int k = 1; k <= 2 + DB; k++) begin
            step(1);
            if (k == PL) vunder = 1'b0;
        end
        clr = 2'b10;
        step(1);
        clr = 2'b00;
        check("vun_set_beats_clr", 32'(status), 2);
        check("vun_no_rst_req", 32'(rst_req), 0);
        step(10);
        check("vun_status_kept", 32'(status), 2);
        check("vun_irq", 32'(irq), 1);
        check("vun_rst_req_quiet", 32'(rst_req), 0);
        clr = 2'b10;
        step(1);
        clr = 2'b00;
        check("vun_clr_status", 32'(status), 0);
        step(1);
        check("vun_clr_irq", 32'(irq), 0);

        // Disable while tripped
        out = 1'b1;
        step(3 + DB);
        check("dis_tripped", 32'(rst_req), 1);
        cfg_ena = 1'b0;
        step(1);
        out = 1'b0;
        check("dis_ena", 32'(ena), 0);
        check("dis_ready", 32'(ready), 0);
        check("dis_rst_req", 32'(rst_req), 0);
        check("dis_status_kept", 32'(status[0]), 1);
        step(10);

        clr = 2'b11;
        step(1);
        clr = 2'b00;

        // Asynchronous reset mid-settle
        cfg_ena = 1'b1;
        step(5);
        check("arst_pre_ena", 32'(ena), 1);
        #2 rst = 1'b1;
        #1;
        check("arst_ena", 32'(ena), 0);
        check("arst_otrip", 32'(otrip), 0);
        check("arst_vtrip", 32'(vtrip), 0);
        check("arst_ready", 32'(ready), 0);
        check("arst_status", 32'(status), 0);
        check("arst_irq", 32'(irq), 0);
        check("arst_rst_req", 32'(rst_req), 0);
        cfg_ena = 1'b0;
        #1 rst = 1'b0;
        step(2);
        check("post_arst_otrip_track", 32'(otrip), 5);
        check("post_arst_ena", 32'(ena), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
